io_stream_arbiter: RTL

Round-robin, packet-locked arbiter that shares one user-project output stream (the path feeding the mprj_io count/status pins) among NREQ requesters, such as the firmware CSR port and hardware test blocks. A requester holds the grant from its first beat until its `last` beat is accepted, so packets are never interleaved. A watchdog revokes a grant from a requester that stalls mid-packet. The block sits between the requesters and the IO output register stage inside the user project wrapper.

---
 rtl/io_stream_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/io_stream_arbiter.sv
// Round-robin, packet-locked arbiter that merges NREQ beat streams onto one
// registered output stream, with a watchdog that revokes a stalled grant.
module io_stream_arbiter #(
  parameter int NREQ    = 2,
  parameter int DW      = 8,
  parameter int TIMEOUT = 64
) (
  input  logic               clock,
  input  logic               resetb,
  input  logic [NREQ-1:0]    req_val,
  input  logic [NREQ-1:0]    req_last,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_rdy,
  output logic               out_val,
  output logic [DW-1:0]      out_data,
  output logic               out_last,
  output logic [1:0]         out_src,
  input  logic               out_rdy,
  output logic               busy,
  output logic               err_timeout
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  localparam logic [1:0] LAST_IDX   = 2'(NREQ - 1);
  localparam logic [7:0] IDLE_LIMIT = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);
  localparam bit         WD_EN      = (TIMEOUT != 0);

  state_t          r_state;
  logic [1:0]      r_grant;
  logic [1:0]      r_ptr;
  logic [7:0]      r_idle_cnt;
  logic            r_out_val;
  logic [DW-1:0]   r_out_data;
  logic            r_out_last;
  logic [1:0]      r_out_src;
  logic            r_err_timeout;

  logic [3:0]      w_val_pad;
  logic [3:0]      w_last_pad;
  logic [DW-1:0]   w_data_pad [4];
  logic            w_space;
  logic            w_granted_space;
  logic            w_val_g;
  logic            w_last_g;
  logic [DW-1:0]   w_data_g;
  logic            w_xfer;
  logic [1:0]      w_ptr_next;
  logic            w_found;
  logic [1:0]      w_winner;

  // Requester vectors are padded to four lanes so a 2-bit grant can index them.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      if (gi < NREQ) begin : g_used
        assign w_val_pad[gi]  = req_val[gi];
        assign w_last_pad[gi] = req_last[gi];
        assign w_data_pad[gi] = req_data[gi*DW +: DW];
        assign req_rdy[gi]    = w_granted_space && (r_grant == 2'(gi));
      end else begin : g_unused
        assign w_val_pad[gi]  = 1'b0;
        assign w_last_pad[gi] = 1'b0;
        assign w_data_pad[gi] = '0;
      end
    end
  endgenerate

  assign w_space         = !r_out_val || out_rdy;
  assign w_granted_space = (r_state == S_GRANT) && w_space;
  assign w_val_g         = w_val_pad[r_grant];
  assign w_last_g        = w_last_pad[r_grant];
  assign w_data_g        = w_data_pad[r_grant];
  assign w_xfer          = w_granted_space && w_val_g;
  assign w_ptr_next      = (r_grant == LAST_IDX) ? 2'd0 : r_grant + 2'd1;

  // Round-robin scan: first valid requester at or after r_ptr, wrapping.
  always_comb begin
    logic [2:0] w_sum;
    w_found  = 1'b0;
    w_winner = r_ptr;
    w_sum    = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_sum = {1'b0, r_ptr} + 3'(k);
      if (w_sum >= 3'(NREQ)) begin
        w_sum = w_sum - 3'(NREQ);
      end
      if (!w_found && w_val_pad[w_sum[1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_sum[1:0];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetb) begin
      r_state       <= S_IDLE;
      r_grant       <= 2'd0;
      r_ptr         <= 2'd0;
      r_idle_cnt    <= 8'd0;
      r_out_val     <= 1'b0;
      r_out_data    <= '0;
      r_out_last    <= 1'b0;
      r_out_src     <= 2'd0;
      r_err_timeout <= 1'b0;
    end else begin
      r_err_timeout <= 1'b0;

      // The output register drains in either state; it only loads on a transfer.
      if (w_xfer) begin
        r_out_val  <= 1'b1;
        r_out_data <= w_data_g;
        r_out_last <= w_last_g;
        r_out_src  <= r_grant;
      end else if (out_rdy) begin
        r_out_val  <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant    <= w_winner;
            r_idle_cnt <= 8'd0;
            r_state    <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (w_xfer) begin
            r_idle_cnt <= 8'd0;
            if (w_last_g) begin
              r_state <= S_IDLE;
              r_ptr   <= w_ptr_next;
            end
          end else if (!w_val_g) begin
            // Only requester idleness counts; downstream backpressure never does.
            if (WD_EN && (r_idle_cnt == IDLE_LIMIT)) begin
              r_state       <= S_IDLE;
              r_ptr         <= w_ptr_next;
              r_err_timeout <= 1'b1;
            end else begin
              r_idle_cnt <= r_idle_cnt + 8'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_val     = r_out_val;
  assign out_data    = r_out_data;
  assign out_last    = r_out_last;
  assign out_src     = r_out_src;
  assign busy        = (r_state == S_GRANT);
  assign err_timeout = r_err_timeout;

endmodule
